anim_sequencer: RTL and testbench

//  Parametrised, table-driven animation sequencer replacing per-animation frame FSMs.

---
 rtl/anim_pkg.sv | 67 ++++++
 rtl/anim_frame_rom.sv | 22 ++
 rtl/anim_sequencer.sv | 128 ++++++++++++
 tb/tb_anim_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Package for the table-driven animation sequencer: movement_state encoding,
// geometry parameters, per-animation constant tables and the frame ROM contents.
// Optional feature macro: ANIM_HITBOX_EN (adds a per-frame hitbox bit).
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    JUMP   = 2'd2,
    ATTACK = 2'd3
  } movement_state;

  localparam int NUM_ANIMS  = 4;
  localparam int MAX_FRAMES = 8;
  localparam int HOLD_W     = 4;
  localparam int COORD_W    = 11;
  localparam int WIDTH_W    = 6;
  localparam int FRAME_W    = $clog2(MAX_FRAMES);
  localparam int NF_W       = $clog2(MAX_FRAMES + 1);
  localparam int MOVE_W     = $bits(movement_state);

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [HOLD_W-1:0]  hold;
`ifdef ANIM_HITBOX_EN
    logic               hitbox;
`endif
  } frame_entry_t;

  // Frames per animation (0 would be treated as a single frame)
  localparam logic [NF_W-1:0] NFRAMES [NUM_ANIMS] = '{4'd3, 4'd6, 4'd5, 4'd4};

  // One-shot animations lock out requests until their last frame completes
  localparam logic ONESHOT [NUM_ANIMS] = '{1'b0, 1'b0, 1'b1, 1'b1};

  // Sprite width per animation; also the column stride between frames
  localparam logic [WIDTH_W-1:0] WIDTH [NUM_ANIMS] = '{6'd16, 6'd20, 6'd24, 6'd32};

  // Sprite-sheet row holding each animation's strip
  localparam logic [COORD_W-1:0] ROW_BASE [NUM_ANIMS] = '{11'd8, 11'd40, 11'd72, 11'd104};

  // anim_ticks per frame; entries past NFRAMES are never reached
  localparam logic [HOLD_W-1:0] HOLD [NUM_ANIMS][MAX_FRAMES] = '{
    '{4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd3, 4'd0, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0},
    '{4'd1, 4'd2, 4'd0, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0},
    '{4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}
  };

`ifdef ANIM_HITBOX_EN
  // Bit f set = frame f carries an active hitbox
  localparam logic [MAX_FRAMES-1:0] HITBOX [NUM_ANIMS] =
    '{8'b0000_0000, 8'b0000_0000, 8'b0000_1000, 8'b0000_0110};
`endif

  // A hold of zero still shows the frame for one tick
  function automatic logic [HOLD_W-1:0] hold_eff(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  // An empty animation still has its frame 0
  function automatic logic [NF_W-1:0] nframes_eff(input logic [NF_W-1:0] n);
    return (n == '0) ? NF_W'(1) : n;
  endfunction

endpackage

// File: rtl/anim_frame_rom.sv
// Combinational frame ROM: (animation, frame) -> row/col offset, hold count
// and, with ANIM_HITBOX_EN defined, the hitbox bit.
module anim_frame_rom
  import anim_pkg::*;
(
  input  logic [MOVE_W-1:0]  anim,
  input  logic [FRAME_W-1:0] frame,
  output frame_entry_t       entry
);

  // Row is fixed per animation strip; columns step by the sprite width
  always_comb begin
    entry      = '0;
    entry.row  = ROW_BASE[anim];
    entry.col  = COORD_W'(frame) * COORD_W'(WIDTH[anim]);
    entry.hold = HOLD[anim][frame];
`ifdef ANIM_HITBOX_EN
    entry.hitbox = HITBOX[anim][frame];
`endif
  end

endmodule

// File: rtl/anim_sequencer.sv
// Table-driven animation sequencer. Advances the frame of the requested
// movement animation on each anim_tick strobe using per-frame hold counts
// from anim_frame_rom; one-shot animations lock out requests until done.
// Optional feature macro: ANIM_HITBOX_EN (adds the hitbox_active output).
module anim_sequencer
  import anim_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               anim_tick,
  input  logic [MOVE_W-1:0]  move_anim,
  output logic [COORD_W-1:0] anim_row,
  output logic [COORD_W-1:0] anim_col,
  output logic [5:0]         max_width,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               anim_lock,
  output logic               anim_done
`ifdef ANIM_HITBOX_EN
  ,
  output logic               hitbox_active
`endif
);

  movement_state      curr_anim;
  movement_state      req_anim;
  logic [HOLD_W-1:0]  hold_cnt;

  movement_state      nxt_anim;
  logic [FRAME_W-1:0] nxt_frame;
  logic [HOLD_W-1:0]  nxt_hold;
  logic               nxt_lock;
  logic               nxt_done;

  logic [HOLD_W-1:0]  cur_hold;
  logic [NF_W-1:0]    cur_nf;
  logic               last_frame;
  logic               oneshot_parked;

  frame_entry_t       nxt_entry;
  frame_entry_t       frame_ent;

  // Requests outside the animation table fall back to IDLE
  always_comb begin
    req_anim = IDLE;
    if (int'(move_anim) < NUM_ANIMS) req_anim = movement_state'(move_anim);
  end

  // frame_ent always mirrors ROM(curr_anim, frame_idx), so its hold field
  // is the dwell of the frame currently on screen
  assign cur_hold       = hold_eff(frame_ent.hold);
  assign cur_nf         = nframes_eff(NFRAMES[curr_anim]);
  assign last_frame     = (NF_W'(frame_idx) >= cur_nf - NF_W'(1));
  assign oneshot_parked = ONESHOT[curr_anim] && !anim_lock;

  // Next-state: reset, then on a tick change > hold > frame advance
  always_comb begin
    nxt_anim  = curr_anim;
    nxt_frame = frame_idx;
    nxt_hold  = hold_cnt;
    nxt_lock  = anim_lock;
    nxt_done  = 1'b0;
    if (reset) begin
      nxt_anim  = IDLE;
      nxt_frame = '0;
      nxt_hold  = '0;
      nxt_lock  = 1'b0;
    end else if (anim_tick) begin
      if ((req_anim != curr_anim) && !anim_lock) begin
        nxt_anim  = req_anim;
        nxt_frame = '0;
        nxt_hold  = '0;
        nxt_lock  = ONESHOT[req_anim];
      end else if (oneshot_parked) begin
        // finished one-shot rests on its last frame until a new request
        nxt_hold = hold_cnt;
      end else if (hold_cnt < cur_hold - HOLD_W'(1)) begin
        nxt_hold = hold_cnt + HOLD_W'(1);
      end else begin
        nxt_hold = '0;
        if (!last_frame) begin
          nxt_frame = frame_idx + FRAME_W'(1);
        end else if (!ONESHOT[curr_anim]) begin
          nxt_frame = '0;
        end else begin
          nxt_done = 1'b1;
          nxt_lock = 1'b0;
        end
      end
    end
  end

  anim_frame_rom u_rom (
    .anim  (nxt_anim),
    .frame (nxt_frame),
    .entry (nxt_entry)
  );

  // Control state: animation, frame, hold counter, lock and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      curr_anim <= IDLE;
      frame_idx <= '0;
      hold_cnt  <= '0;
      anim_lock <= 1'b0;
      anim_done <= 1'b0;
    end else begin
      curr_anim <= nxt_anim;
      frame_idx <= nxt_frame;
      hold_cnt  <= nxt_hold;
      anim_lock <= nxt_lock;
      anim_done <= nxt_done;
    end
  end

  // Output data registers load the ROM entry of the next state so they
  // line up with frame_idx; during reset that next state is (IDLE, 0)
  always_ff @(posedge clk) begin
    frame_ent <= nxt_entry;
    max_width <= WIDTH[nxt_anim];
  end

  assign anim_row = frame_ent.row;
  assign anim_col = frame_ent.col;
`ifdef ANIM_HITBOX_EN
  assign hitbox_active = frame_ent.hitbox;
`endif

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed scenarios followed by
// randomized ticks/requests/resets, compared against a behavioural model.
module tb_anim_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        anim_tick = 1'b0;
  logic [1:0]  move_anim = 2'd0;
  logic [10:0] anim_row;
  logic [10:0] anim_col;
  logic [5:0]  max_width;
  logic [2:0]  frame_idx;
  logic        anim_lock;
  logic        anim_done;
`ifdef ANIM_HITBOX_EN
  logic        hitbox_active;
`endif

  anim_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .anim_tick (anim_tick),
    .move_anim (move_anim),
    .anim_row  (anim_row),
    .anim_col  (anim_col),
    .max_width (max_width),
    .frame_idx (frame_idx),
    .anim_lock (anim_lock),
    .anim_done (anim_done)
`ifdef ANIM_HITBOX_EN
    ,
    .hitbox_active (hitbox_active)
`endif
  );

  always #5 clk = ~clk;

  // Reference animation tables
  int m_nf[4]       = '{3, 6, 5, 4};
  bit m_os[4]       = '{0, 0, 1, 1};
  int m_w[4]        = '{16, 20, 24, 32};
  int m_rowb[4]     = '{8, 40, 72, 104};
  int m_hold[4][8]  = '{'{4, 4, 4, 0, 0, 0, 0, 0},
                        '{3, 0, 3, 3, 2, 1, 0, 0},
                        '{1, 2, 0, 3, 2, 0, 0, 0},
                        '{2, 2, 2, 2, 0, 0, 0, 0}};
  bit m_hit[4][8]   = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                        '{0, 0, 0, 0, 0, 0, 0, 0},
                        '{0, 0, 0, 1, 0, 0, 0, 0},
                        '{0, 1, 1, 0, 0, 0, 0, 0}};

  // Model state: which animation, which frame, ticks spent on that frame
  int m_anim, m_frame, m_ticks;
  bit m_lock, m_done, m_finished;

  int n_checks = 0;
  int n_pass   = 0;
  string phase = "init";

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", phase, tag, obs, exp);
  endtask

  task automatic model_step(input bit rst, input bit tick, input int req);
    int r, h, nf;
    m_done = 0;
    if (rst) begin
      m_anim = 0; m_frame = 0; m_ticks = 0; m_lock = 0; m_finished = 0;
      return;
    end
    if (!tick) return;
    r = (req >= 4) ? 0 : req;
    if (r != m_anim && !m_lock) begin
      m_anim = r; m_frame = 0; m_ticks = 0; m_lock = m_os[r]; m_finished = 0;
      return;
    end
    if (m_finished) return;
    h  = (m_hold[m_anim][m_frame] == 0) ? 1 : m_hold[m_anim][m_frame];
    nf = (m_nf[m_anim] == 0) ? 1 : m_nf[m_anim];
    m_ticks++;
    if (m_ticks < h) return;
    m_ticks = 0;
    if (m_frame + 1 < nf) m_frame++;
    else if (!m_os[m_anim]) m_frame = 0;
    else begin
      m_done = 1; m_lock = 0; m_finished = 1;
    end
  endtask

  task automatic check_all();
    chk("frame_idx", int'(frame_idx), m_frame);
    chk("anim_lock", int'(anim_lock), int'(m_lock));
    chk("anim_done", int'(anim_done), int'(m_done));
    chk("anim_row",  int'(anim_row),  m_rowb[m_anim]);
    chk("anim_col",  int'(anim_col),  m_frame * m_w[m_anim]);
    chk("max_width", int'(max_width), m_w[m_anim]);
`ifdef ANIM_HITBOX_EN
    chk("hitbox",    int'(hitbox_active), int'(m_hit[m_anim][m_frame]));
`endif
  endtask

  task automatic step(input bit rst, input bit tick, input int req);
    reset = rst;
    anim_tick = tick;
    move_anim = 2'(req);
    @(posedge clk);
    model_step(rst, tick, req);
    #1;
    check_all();
  endtask

  int cur_req;

  initial begin
    // 1: reset held three clocks
    phase = "reset";
    for (int i = 0; i < 3; i++) step(1, 1, 3);

    // 2: IDLE loops through 3 frames of 4 ticks each
    phase = "idle_loop";
    for (int i = 0; i < 24; i++) step(0, 1, 0);

    // 3: WALK to frame 2 / second tick, then switch back to IDLE
    phase = "walk_switch";
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    step(0, 1, 0);
    step(0, 0, 0);

    // 4: ATTACK one-shot with an ignored WALK request, then release
    phase = "attack";
    step(0, 1, 3);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, (i == 3) ? 1 : 3);
      step(0, 0, 1);
    end
    step(0, 1, 3);
    step(0, 1, 3);
    step(0, 1, 1);

    // 5: zero-hold frame and tick gaps with changing requests
    phase = "gaps";
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1);
      for (int g = 0; g < 5; g++) step(0, 0, int'($urandom_range(0, 3)));
    end

    // 6: reset in the middle of an ATTACK tick
    phase = "reset_mid";
    step(0, 1, 3);
    step(0, 1, 3);
    step(0, 1, 3);
    step(1, 1, 3);
    step(0, 0, 3);

    // Randomized: sticky requests, random ticks, rare resets
    phase = "random";
    cur_req = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) cur_req = int'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, cur_req);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
